// File: rtl/posit_pkg.sv
// Shared posit constants and elaboration helpers for the posit multiplier arbiter slice.
package posit_pkg;
  localparam int          POSIT_N    = 16;
  localparam int          POSIT_ES   = 3;
  localparam logic [15:0] POSIT_NAR  = 16'h8000;
  localparam logic [15:0] POSIT_ZERO = 16'h0000;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/posit_mult_arbiter_if.sv
// Request/response bus between the requester lanes and the shared posit multiplier.
interface posit_mult_arbiter_if
  import posit_pkg::*;
#(
  parameter int N    = POSIT_N,
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_out;
  logic              rsp_inf;
  logic              rsp_zero;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_inf, rsp_zero, busy
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_out, rsp_inf, rsp_zero, busy
  );
endinterface

// File: rtl/posit_mult.sv
// Combinational posit multiplier, round-to-nearest-even, saturating at maxpos/minpos.
module posit_mult
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES
) (
  input  logic         start,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic [N-1:0] out,
  output logic         inf,
  output logic         zero,
  output logic         done
);
  localparam int FW    = N - 1 - ES;
  localparam int MW    = FW + 1;
  localparam int FRW   = 2 * MW - 1;
  localparam int CW    = 64;
  localparam int MAXSC = (N - 2) * (1 << ES);
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  function automatic void decode(input logic [N-1:0] x, output int sc, output logic [FW:0] mant);
    logic [N-2:0] rem, sh;
    logic         r0, stop;
    int           m;
    rem  = x[N-1] ? (N-1)'(-x) : x[N-2:0];
    r0   = rem[N-2];
    m    = 0;
    stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop && rem[i] == r0) m++;
      else stop = 1'b1;
    end
    sh   = rem << (m + 1);
    sc   = (r0 ? m - 1 : -m) * (1 << ES) + int'(sh[N-2 -: ES]);
    mant = {1'b1, sh[FW-1:0]};
  endfunction

  int              sa, sb, sc, k, e, rlen;
  logic [FW:0]     ma, mb;
  logic [2*MW-1:0] prod;
  logic [FRW-1:0]  frac;
  logic [CW-1:0]   rbits, tail_al, comb;
  logic [N-2:0]    mag, magr;
  logic [N-1:0]    res;
  logic            guard, sticky, nar, zr;

  always_comb begin
    decode(in1, sa, ma);
    decode(in2, sb, mb);
    prod = {{MW{1'b0}}, ma} * {{MW{1'b0}}, mb};
    sc   = sa + sb + int'(prod[2*MW-1]);
    frac = prod[2*MW-1] ? prod[2*MW-2:0] : {prod[2*MW-3:0], 1'b0};
    k    = sc >>> ES;
    e    = sc - k * (1 << ES);
    // Regime run is laid out MSB-first; exponent and fraction follow it.
    if (k >= 0) begin
      rbits = ~({CW{1'b1}} >> (k + 1));
      rlen  = k + 2;
    end else begin
      rbits = {{(CW-1){1'b0}}, 1'b1} << (CW - 1 + k);
      rlen  = 1 - k;
    end
    tail_al = {ES'(e), frac, {(CW-ES-FRW){1'b0}}} >> rlen;
    comb    = rbits | tail_al;
    mag     = comb[CW-1 -: N-1];
    guard   = comb[CW-N];
    sticky  = |comb[CW-N-1:0];
    magr    = mag + (N-1)'(guard & (sticky | mag[0]));
    if (sc > MAXSC)  magr = {(N-1){1'b1}};
    if (sc < -MAXSC) magr = (N-1)'(1);
    res  = (in1[N-1] ^ in2[N-1]) ? -{1'b0, magr} : {1'b0, magr};
    nar  = (in1 == NAR) || (in2 == NAR);
    zr   = !nar && ((in1 == '0) || (in2 == '0));
    out  = nar ? NAR : (zr ? '0 : res);
    inf  = nar;
    zero = zr;
    done = start;
  end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first valid request at or after ptr, as one-hot grant plus index.
module rr_arbiter
  import posit_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!any && req[(int'(ptr) + j) % NREQ]) begin
        any = 1'b1;
        gnt[(int'(ptr) + j) % NREQ] = 1'b1;
        idx = IDW'((int'(ptr) + j) % NREQ);
      end
    end
  end
endmodule

// File: rtl/posit_mult_arbiter.sv
// Shares one posit_mult among NREQ requesters: round-robin grant, operand stage S1, result stage S2.
module posit_mult_arbiter
  import posit_pkg::*;
#(
  parameter int N    = POSIT_N,
  parameter int ES   = POSIT_ES,
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic clk,
  input  logic rst_n,
  posit_mult_arbiter_if.slave bus
);
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            s1_valid_q, s1_valid_d;
  logic [N-1:0]    s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [N-1:0]    rsp_out_q, rsp_out_d;
  logic            rsp_inf_q, rsp_inf_d, rsp_zero_q, rsp_zero_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            s1_ready, s2_ready, accept, move;
  logic [N-1:0]    pm_out;
  logic            pm_inf, pm_zero, pm_done;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(bus.req_valid), .ptr(rr_ptr_q), .gnt(gnt), .idx(gnt_idx), .any(gnt_any)
  );

  posit_mult #(.N(N), .ES(ES)) u_mult (
    .start(s1_valid_q), .in1(s1_a_q), .in2(s1_b_q),
    .out(pm_out), .inf(pm_inf), .zero(pm_zero), .done(pm_done)
  );

  always_comb begin
    s2_ready      = !rsp_valid_q || bus.rsp_ready;
    s1_ready      = !s1_valid_q || s2_ready;
    // Held low in reset so no requester sees an accept that the flops will not take.
    bus.req_ready = gnt & {NREQ{s1_ready & rst_n}};
    accept        = gnt_any && s1_ready;
    move          = s1_valid_q && s2_ready;

    s1_valid_d = accept || (s1_valid_q && !s2_ready);
    s1_a_d     = accept ? bus.req_a[int'(gnt_idx)*N +: N] : s1_a_q;
    s1_b_d     = accept ? bus.req_b[int'(gnt_idx)*N +: N] : s1_b_q;
    s1_id_d    = accept ? gnt_idx : s1_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept) rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

    rsp_valid_d = move || (rsp_valid_q && !bus.rsp_ready);
    rsp_out_d   = move ? pm_out  : rsp_out_q;
    rsp_inf_d   = move ? pm_inf  : rsp_inf_q;
    rsp_zero_d  = move ? pm_zero : rsp_zero_q;
    rsp_id_d    = move ? s1_id_q : rsp_id_q;
  end

  // S1 operand stage (data) and control/result stage (S2).
  always_ff @(posedge clk) begin
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
    s1_id_q <= s1_id_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= '0;
      rsp_inf_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      s1_valid_q  <= s1_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      rsp_inf_q   <= rsp_inf_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_inf   = rsp_inf_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = s1_valid_q | rsp_valid_q;

  a_done_follows_start: assert property (@(posedge clk) disable iff (!rst_n) pm_done == s1_valid_q);
endmodule

// File: tb/tb_posit_mult_arbiter.sv
// Scoreboard bench for posit_mult_arbiter: directed operands with hand-computed products.
module tb_posit_mult_arbiter;
  import posit_pkg::*;
  localparam int N = 16, NREQ = 4, IDW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  posit_mult_arbiter_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();
  posit_mult_arbiter #(.N(N), .ES(3), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [N-1:0]   out;
    logic           inf;
    logic           zero;
  } rsp_t;

  rsp_t            sb[$];
  rsp_t            exp_l[NREQ];
  int              acc_id[$];
  int              acc_cyc[$];
  int              n_cmp = 0, n_err = 0, cyc = 0;
  logic [NREQ-1:0] hs = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Accepts push the lane's expected result; valid responses pop and compare.
  always @(negedge clk) begin
    cyc++;
    hs = bus.req_valid & bus.req_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        sb.push_back(exp_l[i]);
        acc_id.push_back(i);
        acc_cyc.push_back(cyc);
      end
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_id",   32'(bus.rsp_id),   32'(e.id));
        chk("rsp_out",  32'(bus.rsp_out),  32'(e.out));
        chk("rsp_inf",  32'(bus.rsp_inf),  32'(e.inf));
        chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
      end
    end
  end

  task automatic drive(input int lane, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] o, input logic fi, input logic fz);
    bus.req_a[lane*N +: N] = a;
    bus.req_b[lane*N +: N] = b;
    exp_l[lane] = {IDW'(lane), o, fi, fz};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_drop();
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~hs;
  endtask

  task automatic run_batch(input logic [NREQ-1:0] mask);
    int k;
    bus.req_valid = mask;
    k = 0;
    while (bus.req_valid != '0 && k < 50) begin
      tick_drop();
      k++;
    end
    chk("batch_accepted", 32'(bus.req_valid), 32'd0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((bus.busy || sb.size() != 0) && k < 50) begin
      tick();
      k++;
    end
    chk("drain", 32'(sb.size()) | 32'(bus.busy), 32'd0);
  endtask

  function automatic int acc_at(input int i);
    return (i < acc_id.size()) ? acc_id[i] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state, with requests pending to prove req_ready is gated.
    bus.req_valid = '1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_rsp_out",   32'(bus.rsp_out),   32'd0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
    chk("rst_flags",     {30'd0, bus.rsp_inf, bus.rsp_zero}, 32'd0);
    bus.req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Single request on lane 0, latency of two edges.
    drive(0, 16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_req_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '0;
    chk("t1_valid_after_T",  32'(bus.rsp_valid), 32'd0);
    chk("t1_busy_after_T",   32'(bus.busy),      32'd1);
    tick();
    chk("t1_valid_after_T1", 32'(bus.rsp_valid), 32'd1);
    wait_idle();

    // All lanes continuously valid: rotating grants, one accept per cycle.
    for (int i = 0; i < NREQ; i++) drive(i, 16'h4400, 16'h4400, 16'h4800, 1'b0, 1'b0);
    acc_id.delete();
    acc_cyc.delete();
    bus.req_valid = '1;
    begin
      int k;
      k = 0;
      while (acc_id.size() < 8 && k < 40) begin
        tick();
        k++;
      end
    end
    bus.req_valid = '0;
    for (int i = 0; i < 8; i++) chk($sformatf("t2_grant%0d", i), 32'(acc_at(i)), 32'((i + 1) % 4));
    chk("t2_back_to_back", 32'(acc_cyc.size() >= 8 ? acc_cyc[7] - acc_cyc[0] : -1), 32'd7);
    wait_idle();

    // Specials and arithmetic corners.
    drive(0, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1);
    drive(1, 16'h8000, 16'h4000, POSIT_NAR, 1'b1, 1'b0);
    drive(2, 16'hC000, 16'h4000, 16'hC000, 1'b0, 1'b0);
    drive(3, 16'h4400, 16'hC000, 16'hBC00, 1'b0, 1'b0);
    run_batch(4'b1111);
    drive(0, 16'h4200, 16'h4200, 16'h4480, 1'b0, 1'b0);
    drive(1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    drive(2, 16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0);
    drive(3, 16'h4800, 16'h4800, 16'h5000, 1'b0, 1'b0);
    run_batch(4'b1111);
    drive(0, 16'h5000, 16'h5000, 16'h6000, 1'b0, 1'b0);
    drive(1, 16'h8000, 16'h0000, POSIT_NAR, 1'b1, 1'b0);
    run_batch(4'b0011);
    wait_idle();

    // Backpressure: two accepts fill S1/S2, third lane waits.
    drive(0, 16'h4000, 16'h4000, 16'h4000, 1'b0, 1'b0);
    drive(1, 16'h4400, 16'h4400, 16'h4800, 1'b0, 1'b0);
    drive(2, 16'h4800, 16'h4800, 16'h5000, 1'b0, 1'b0);
    bus.rsp_ready = 1'b0;
    n0 = acc_id.size();
    bus.req_valid = 4'b0111;
    repeat (5) tick_drop();
    chk("t4_accepts_held", 32'(acc_id.size() - n0), 32'd2);
    @(negedge clk);
    chk("t4_req_ready_zero", 32'(bus.req_ready), 32'd0);
    chk("t4_rsp_out_held",   32'(bus.rsp_out),   32'h4800);
    chk("t4_rsp_id_held",    32'(bus.rsp_id),    32'd1);
    tick();
    @(negedge clk);
    chk("t4_rsp_out_stable", 32'(bus.rsp_out),   32'h4800);
    chk("t4_rsp_valid",      32'(bus.rsp_valid), 32'd1);
    tick();
    bus.rsp_ready = 1'b1;
    run_batch(bus.req_valid);
    wait_idle();
    chk("t4_order0", 32'(acc_at(n0)),     32'd1);
    chk("t4_order1", 32'(acc_at(n0 + 1)), 32'd2);
    chk("t4_order2", 32'(acc_at(n0 + 2)), 32'd0);

    // Pointer wrap: move pointer to 3, then lanes 3 and 0 compete.
    drive(2, 16'h4400, 16'hC000, 16'hBC00, 1'b0, 1'b0);
    run_batch(4'b0100);
    wait_idle();
    chk("t5_ptr_at_3", 32'(dut.rr_ptr_q), 32'd3);
    drive(3, 16'h4400, 16'h4000, 16'h4400, 1'b0, 1'b0);
    drive(0, 16'hC000, 16'hC000, 16'h4000, 1'b0, 1'b0);
    n0 = acc_id.size();
    run_batch(4'b1001);
    wait_idle();
    chk("t5_grant_first",  32'(acc_at(n0)),     32'd3);
    chk("t5_grant_second", 32'(acc_at(n0 + 1)), 32'd0);
    chk("t5_ptr_end",      32'(dut.rr_ptr_q),   32'd1);

    // Reset with both stages full discards in-flight work.
    drive(1, 16'h4400, 16'h4400, 16'h4800, 1'b0, 1'b0);
    drive(2, 16'h0000, 16'h4400, 16'h0000, 1'b0, 1'b1);
    bus.rsp_ready = 1'b0;
    run_batch(4'b0110);
    chk("t6_full_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t6_full_s1",    32'(dut.s1_valid_q), 32'd1);
    bus.req_valid = 4'b0110;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t6_rst_busy",      32'(bus.busy),      32'd0);
    chk("t6_rst_req_ready", 32'(bus.req_ready), 32'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    n0 = acc_id.size();
    run_batch(4'b0110);
    wait_idle();
    chk("t6_first_grant", 32'(acc_at(n0)), 32'd1);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
